smem_dcache_switch: RTL

Per-lane router between the LSU data-memory port and the two memory targets: the data cache and the core-local shared memory. Request lanes are steered by the shared-memory type bit carried in bit 0 of each lane's request tag, and each target gets a registered, elastic request stage. Responses from both targets are merged back onto the single LSU response port through a round-robin arbiter and one output register. The block sits directly downstream of the LSU unit, which consumes the merged response port.

---
 rtl/smem_dcache_switch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/smem_dcache_switch.sv
// Per-lane request router between the LSU and the data cache / shared memory, with
// a round-robin merge of both response streams onto one registered LSU response port.
module smem_dcache_switch #(
  parameter int NUM_THREADS = 4,
  parameter int WORD_SIZE   = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,

  input  logic [NUM_THREADS-1:0]                  in_req_valid,
  output logic [NUM_THREADS-1:0]                  in_req_ready,
  input  logic [NUM_THREADS-1:0]                  in_req_rw,
  input  logic [NUM_THREADS*WORD_SIZE-1:0]        in_req_byteen,
  input  logic [NUM_THREADS*ADDR_WIDTH-1:0]       in_req_addr,
  input  logic [NUM_THREADS*8*WORD_SIZE-1:0]      in_req_data,
  input  logic [NUM_THREADS*TAG_WIDTH-1:0]        in_req_tag,

  output logic                                    in_rsp_valid,
  input  logic                                    in_rsp_ready,
  output logic [NUM_THREADS-1:0]                  in_rsp_tmask,
  output logic [NUM_THREADS*8*WORD_SIZE-1:0]      in_rsp_data,
  output logic [TAG_WIDTH-1:0]                    in_rsp_tag,

  output logic [NUM_THREADS-1:0]                  dc_req_valid,
  input  logic [NUM_THREADS-1:0]                  dc_req_ready,
  output logic [NUM_THREADS-1:0]                  dc_req_rw,
  output logic [NUM_THREADS*WORD_SIZE-1:0]        dc_req_byteen,
  output logic [NUM_THREADS*ADDR_WIDTH-1:0]       dc_req_addr,
  output logic [NUM_THREADS*8*WORD_SIZE-1:0]      dc_req_data,
  output logic [NUM_THREADS*TAG_WIDTH-1:0]        dc_req_tag,

  output logic [NUM_THREADS-1:0]                  sm_req_valid,
  input  logic [NUM_THREADS-1:0]                  sm_req_ready,
  output logic [NUM_THREADS-1:0]                  sm_req_rw,
  output logic [NUM_THREADS*WORD_SIZE-1:0]        sm_req_byteen,
  output logic [NUM_THREADS*ADDR_WIDTH-1:0]       sm_req_addr,
  output logic [NUM_THREADS*8*WORD_SIZE-1:0]      sm_req_data,
  output logic [NUM_THREADS*TAG_WIDTH-1:0]        sm_req_tag,

  input  logic                                    dc_rsp_valid,
  output logic                                    dc_rsp_ready,
  input  logic [NUM_THREADS-1:0]                  dc_rsp_tmask,
  input  logic [NUM_THREADS*8*WORD_SIZE-1:0]      dc_rsp_data,
  input  logic [TAG_WIDTH-1:0]                    dc_rsp_tag,

  input  logic                                    sm_rsp_valid,
  output logic                                    sm_rsp_ready,
  input  logic [NUM_THREADS-1:0]                  sm_rsp_tmask,
  input  logic [NUM_THREADS*8*WORD_SIZE-1:0]      sm_rsp_data,
  input  logic [TAG_WIDTH-1:0]                    sm_rsp_tag
);

  localparam int DW  = 8 * WORD_SIZE;
  localparam int PW  = 1 + WORD_SIZE + ADDR_WIDTH + DW + TAG_WIDTH;
  localparam int RSW = NUM_THREADS + NUM_THREADS * DW + TAG_WIDTH;

  // ---------------------------------------------------------------------------
  // Request path: one elastic 1-entry stage per lane and per target
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_lane
    logic          w_sel;
    logic          w_dc_load;
    logic          w_sm_load;
    logic [PW-1:0] w_in_payload;
    logic          r_dc_valid;
    logic          r_sm_valid;
    logic [PW-1:0] r_dc_payload;
    logic [PW-1:0] r_sm_payload;

    assign w_sel        = in_req_tag[i*TAG_WIDTH];
    assign w_in_payload = {in_req_rw[i],
                           in_req_byteen[i*WORD_SIZE +: WORD_SIZE],
                           in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                           in_req_data[i*DW +: DW],
                           in_req_tag[i*TAG_WIDTH +: TAG_WIDTH]};

    // A full stage still accepts when it is draining in the same cycle.
    assign in_req_ready[i] = w_sel ? (!r_sm_valid || sm_req_ready[i])
                                   : (!r_dc_valid || dc_req_ready[i]);
    assign w_dc_load = in_req_valid[i] && in_req_ready[i] && !w_sel;
    assign w_sm_load = in_req_valid[i] && in_req_ready[i] &&  w_sel;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_dc_valid <= 1'b0;
        r_sm_valid <= 1'b0;
      end else begin
        if (w_dc_load)            r_dc_valid <= 1'b1;
        else if (dc_req_ready[i]) r_dc_valid <= 1'b0;
        if (w_sm_load)            r_sm_valid <= 1'b1;
        else if (sm_req_ready[i]) r_sm_valid <= 1'b0;
      end
    end

    // NOTE: payload flops are left unreset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
      if (w_dc_load) r_dc_payload <= w_in_payload;
      if (w_sm_load) r_sm_payload <= w_in_payload;
    end

    assign dc_req_valid[i] = r_dc_valid;
    assign sm_req_valid[i] = r_sm_valid;
    assign {dc_req_rw[i],
            dc_req_byteen[i*WORD_SIZE +: WORD_SIZE],
            dc_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
            dc_req_data[i*DW +: DW],
            dc_req_tag[i*TAG_WIDTH +: TAG_WIDTH]} = r_dc_payload;
    assign {sm_req_rw[i],
            sm_req_byteen[i*WORD_SIZE +: WORD_SIZE],
            sm_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
            sm_req_data[i*DW +: DW],
            sm_req_tag[i*TAG_WIDTH +: TAG_WIDTH]} = r_sm_payload;
  end

  // ---------------------------------------------------------------------------
  // Response path: round-robin between cache and smem into one output register
  // ---------------------------------------------------------------------------
  logic           w_accept;
  logic           w_gnt_dc;
  logic           w_gnt_sm;
  logic           r_rsp_valid;
  logic           r_ptr;
  logic [RSW-1:0] r_rsp_payload;

  assign w_accept = !r_rsp_valid || in_rsp_ready;

  // r_ptr only matters when both sources compete: 0 favours cache, 1 favours smem.
  assign w_gnt_dc = dc_rsp_valid && (!sm_rsp_valid || !r_ptr);
  assign w_gnt_sm = sm_rsp_valid && (!dc_rsp_valid ||  r_ptr);

  assign dc_rsp_ready = w_accept && w_gnt_dc;
  assign sm_rsp_ready = w_accept && w_gnt_sm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_ptr       <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= w_gnt_dc || w_gnt_sm;
      if (dc_rsp_valid && sm_rsp_valid) r_ptr <= !r_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (dc_rsp_ready)      r_rsp_payload <= {dc_rsp_tmask, dc_rsp_data, dc_rsp_tag};
    else if (sm_rsp_ready) r_rsp_payload <= {sm_rsp_tmask, sm_rsp_data, sm_rsp_tag};
  end

  assign in_rsp_valid = r_rsp_valid;
  assign {in_rsp_tmask, in_rsp_data, in_rsp_tag} = r_rsp_payload;

endmodule
